// File: rtl/digit_entry_register.sv
// Keypad time-entry stage: debounces the encoder validn/D pair, accepts one
// digit per press and shifts it right-to-left into a 4-digit BCD MM:SS register.
module digit_entry_register #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       validn,
  input  logic       enablen,
  input  logic       clearn,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       digit_strobe,
  output logic [2:0] entry_count,
  output logic       is_zero
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Comparing against N-1 keeps the counter from ever needing to hold N.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);
  localparam logic [2:0]       COUNT_MAX = 3'd4;
  localparam logic [3:0]       BCD_MAX   = 4'd9;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_q, cap_d;
  logic             accept_hit;
  logic [3:0]       accept_digit;

  logic [15:0]      digits_q, digits_d;
  logic [2:0]       count_q, count_d;
  logic             strobe_q, strobe_d;
  logic             accept_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    accept_hit   = 1'b0;
    accept_digit = cap_q;
    if (!enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!validn) begin
            cap_d = D;
            if (SINGLE) begin
              accept_hit   = 1'b1;
              accept_digit = D;
              state_d      = HELD;
              cnt_d        = '0;
            end else begin
              state_d = PRESS_DEB;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PRESS_DEB: begin
          if (validn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (D != cap_q) begin
            // A changed code restarts the stability window on the new digit.
            cap_d = D;
            cnt_d = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            accept_hit = 1'b1;
            state_d    = HELD;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (validn) begin
            if (SINGLE) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE_DEB;
              cnt_d   = CNT_ONE;
            end
          end
        end
        RELEASE_DEB: begin
          if (!validn) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Non-BCD codes still walk the FSM to HELD but never reach the register.
  assign accept_ok = accept_hit && (accept_digit <= BCD_MAX);

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    if (!clearn) begin
      digits_d = '0;
      count_d  = '0;
    end else if (accept_ok) begin
      digits_d = {digits_q[11:0], accept_digit};
      count_d  = (count_q == COUNT_MAX) ? count_q : count_q + 3'd1;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits_q <= '0;
      count_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
    end
  end

  assign min_tens     = digits_q[15:12];
  assign min_ones     = digits_q[11:8];
  assign sec_tens     = digits_q[7:4];
  assign sec_ones     = digits_q[3:0];
  assign digit_strobe = strobe_q;
  assign entry_count  = count_q;
  assign is_zero      = (digits_q == 16'h0000);

endmodule

// File: tb/tb_digit_entry_register.sv
// Scoreboard bench for digit_entry_register with DEBOUNCE_CYCLES=4: each
// expected accept is queued when its press is driven and popped on digit_strobe.
module tb_digit_entry_register;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] D;
  logic       validn, enablen, clearn;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       digit_strobe;
  logic [2:0] entry_count;
  logic       is_zero;

  digit_entry_register #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .D(D), .validn(validn), .enablen(enablen),
    .clearn(clearn), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .digit_strobe(digit_strobe),
    .entry_count(entry_count), .is_zero(is_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [2:0]  count;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [15:0] model_digits = '0;
  logic [2:0]  model_count  = '0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          strobe_seen = 0;
  int          s0;
  wire  [15:0] digits = {min_tens, min_ones, sec_tens, sec_ones};

  always @(negedge clk) begin
    if (resetn && digit_strobe) begin
      sb_entry_t exp_e;
      strobe_seen++;
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_strobe: digits=%h count=%0d, required no strobe", digits, entry_count);
      end else begin
        exp_e = sb_q.pop_front();
        if ({digits, entry_count} !== exp_e)
          $display("FAIL accept_result: digits=%h count=%0d, required digits=%h count=%0d",
                   digits, entry_count, exp_e.digits, exp_e.count);
        else n_pass++;
      end
    end
  end

  task automatic expect_accept(input logic [3:0] d);
    model_digits = {model_digits[11:0], d};
    if (model_count != 3'd4) model_count = model_count + 3'd1;
    sb_q.push_back('{digits: model_digits, count: model_count});
  endtask

  // Entered and left on a falling edge; each cycle is one sampled posedge.
  task automatic press_key(input logic [3:0] d, input int low, input int high, input bit accepted);
    if (accepted) expect_accept(d);
    D = d;
    validn = 1'b0;
    repeat (low) @(negedge clk);
    validn = 1'b1;
    repeat (high) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; validn = 1'b1; D = '0; enablen = 1'b1; clearn = 1'b1;
    #3;
    n_checks++;
    if ({digits, entry_count, digit_strobe, is_zero} !== {16'h0, 3'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: digits=%h count=%0d strobe=%b zero=%b, required 0000/0/0/1",
               digits, entry_count, digit_strobe, is_zero);
    else n_pass++;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    press_key(4'd1, 10, 10, 1'b1);
    expect_accept(4'd9);
    D = 4'd9; validn = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (digit_strobe !== 1'b1) $display("FAIL reset_pre_strobe: strobe=%b, required 1", digit_strobe);
    else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({digits, entry_count, digit_strobe, is_zero} !== {16'h0, 3'd0, 1'b0, 1'b1})
      $display("FAIL reset_midop: digits=%h count=%0d strobe=%b zero=%b, required 0000/0/0/1",
               digits, entry_count, digit_strobe, is_zero);
    else n_pass++;
    model_digits = '0; model_count = '0;
    validn = 1'b1;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL reset_queue: pending=%0d, required 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_sequence();
    s0 = strobe_seen;
    press_key(4'd1, 10, 10, 1'b1);
    press_key(4'd2, 10, 10, 1'b1);
    press_key(4'd3, 10, 10, 1'b1);
    press_key(4'd0, 10, 10, 1'b1);
    n_checks++;
    if ({digits, entry_count, is_zero} !== {16'h1230, 3'd4, 1'b0})
      $display("FAIL seq_value: digits=%h count=%0d zero=%b, required 1230/4/0", digits, entry_count, is_zero);
    else n_pass++;
    n_checks++;
    if (strobe_seen - s0 != 4) $display("FAIL seq_strobes: got=%0d, required 4", strobe_seen - s0);
    else n_pass++;
  endtask

  task automatic test_bounce();
    s0 = strobe_seen;
    press_key(4'd8, 3, 1, 1'b0);
    press_key(4'd8, 3, 6, 1'b0);
    n_checks++;
    if (digits !== model_digits || strobe_seen != s0)
      $display("FAIL bounce: digits=%h strobes=%0d, required %h and 0", digits, strobe_seen - s0, model_digits);
    else n_pass++;
  endtask

  task automatic test_invalid_code();
    s0 = strobe_seen;
    press_key(4'hC, 10, 10, 1'b0);
    press_key(4'hA, 10, 10, 1'b0);
    n_checks++;
    if ({digits, entry_count} !== {model_digits, model_count} || strobe_seen != s0)
      $display("FAIL invalid_code: digits=%h count=%0d strobes=%0d, required %h/%0d and 0",
               digits, entry_count, strobe_seen - s0, model_digits, model_count);
    else n_pass++;
  endtask

  task automatic test_hold();
    s0 = strobe_seen;
    press_key(4'd7, 100, 10, 1'b1);
    n_checks++;
    if (strobe_seen - s0 != 1 || digits !== model_digits)
      $display("FAIL hold: strobes=%0d digits=%h, required 1 and %h", strobe_seen - s0, digits, model_digits);
    else n_pass++;
    clearn = 1'b0;
    @(negedge clk); clearn = 1'b1;
    model_digits = '0; model_count = '0;
    n_checks++;
    if ({digits, entry_count, is_zero} !== {16'h0, 3'd0, 1'b1})
      $display("FAIL clear: digits=%h count=%0d zero=%b, required 0000/0/1", digits, entry_count, is_zero);
    else n_pass++;
    press_key(4'd1, 10, 10, 1'b1);
    press_key(4'd2, 10, 10, 1'b1);
    press_key(4'd3, 10, 10, 1'b1);
    press_key(4'd0, 10, 10, 1'b1);
    press_key(4'd5, 10, 10, 1'b1);
    n_checks++;
    if ({digits, entry_count} !== {16'h2305, 3'd4})
      $display("FAIL fifth_digit: digits=%h count=%0d, required 2305/4", digits, entry_count);
    else n_pass++;
  endtask

  task automatic test_recapture();
    D = 4'd4; validn = 1'b0;
    @(negedge clk); D = 4'd6;
    repeat (3) @(negedge clk);
    n_checks++;
    if (digit_strobe !== 1'b0 || digits !== model_digits)
      $display("FAIL recapture_early: strobe=%b digits=%h, required 0 and %h", digit_strobe, digits, model_digits);
    else n_pass++;
    expect_accept(4'd6);
    @(negedge clk);
    n_checks++;
    if (digit_strobe !== 1'b1 || digits !== model_digits)
      $display("FAIL recapture_edge: strobe=%b digits=%h, required 1 and %h", digit_strobe, digits, model_digits);
    else n_pass++;
    repeat (5) @(negedge clk);
    validn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_enable();
    s0 = strobe_seen;
    enablen = 1'b0;
    press_key(4'd8, 10, 10, 1'b0);
    enablen = 1'b1;
    n_checks++;
    if ({digits, entry_count} !== {model_digits, model_count} || strobe_seen != s0)
      $display("FAIL enable_block: digits=%h count=%0d strobes=%0d, required %h/%0d and 0",
               digits, entry_count, strobe_seen - s0, model_digits, model_count);
    else n_pass++;
  endtask

  task automatic test_clear_on_accept();
    s0 = strobe_seen;
    D = 4'd9; validn = 1'b0;
    repeat (3) @(negedge clk);
    clearn = 1'b0;
    @(negedge clk); clearn = 1'b1;
    model_digits = '0; model_count = '0;
    n_checks++;
    if ({digits, entry_count, digit_strobe} !== {16'h0, 3'd0, 1'b0})
      $display("FAIL clear_accept: digits=%h count=%0d strobe=%b, required 0000/0/0",
               digits, entry_count, digit_strobe);
    else n_pass++;
    repeat (6) @(negedge clk);
    validn = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (strobe_seen != s0 || digits !== 16'h0)
      $display("FAIL clear_held: strobes=%0d digits=%h, required 0 and 0000", strobe_seen - s0, digits);
    else n_pass++;
    press_key(4'd4, 10, 10, 1'b1);
    n_checks++;
    if ({digits, entry_count} !== {16'h0004, 3'd1})
      $display("FAIL after_clear: digits=%h count=%0d, required 0004/1", digits, entry_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_bounce();
    test_invalid_code();
    test_hold();
    test_recapture();
    test_enable();
    test_clear_on_accept();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
